// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: scoreboard-driven hazard unit for the 16-bit five-stage core.
// Tracks the destination registers of the instructions in EX and MEM, registers the
// EX-stage forward selects, raises a one-cycle load-use stall and flushes on a taken
// branch. Event counters report how many stalls and flushes occurred.
//
// Only the scoreboard fields that feed a decision are held. The WB occupant is never
// consulted (the register bank writes before it is read), and the MEM occupant only
// ever needs valid/regWrite/rd, so those are the only bits kept past EX.
module hazard_forward_ctrl #(
  parameter int SAT_CNT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  rs_id,
  input  logic [2:0]  rt_id,
  input  logic [2:0]  rd_id,
  input  logic        regWrite_id,
  input  logic        memRead_id,
  input  logic        branch_id,
  input  logic        zeroEx,
  output logic [1:0]  saidaAfw,
  output logic [1:0]  saidaBfw,
  output logic        pcWrite,
  output logic        ifidWrite,
  output logic        idexBubble,
  output logic        flushIfId,
  output logic [15:0] stallCount,
  output logic [15:0] flushCount
);

  // Forward select codes as seen by the EX-stage operand muxes.
  localparam logic [1:0] FwdBank = 2'b00;  // register bank value
  localparam logic [1:0] FwdMem  = 2'b01;  // resultadoALU_MEM
  localparam logic [1:0] FwdWb   = 2'b10;  // resultadoMux_WB

  // EX slot: the instruction that entered EX at the last edge.
  logic       exValid_reg;
  logic [2:0] exRd_reg;
  logic       exRegWrite_reg;
  logic       exMemRead_reg;
  logic       exBranch_reg;

  // MEM slot: only what a forward decision needs.
  logic       memValid_reg;
  logic [2:0] memRd_reg;
  logic       memRegWrite_reg;

  // Per-operand view (index 0 = operand A / rs, 1 = operand B / rt).
  logic [2:0] srcId [2];
  logic [1:0] exHit;
  logic [1:0] memHit;
  logic [1:0] fwd_next [2];
  logic [1:0] fwd_reg  [2];

  logic stall;
  logic taken;
  logic bubble;

  logic [15:0] stallCount_reg;
  logic [15:0] flushCount_reg;

  assign srcId[0] = rs_id;
  assign srcId[1] = rt_id;

  // One forward path per ALU operand; the nearer producer (EX) wins over MEM.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : genOperand
      assign exHit[gi]  = exValid_reg && exRegWrite_reg &&
                          (exRd_reg == srcId[gi]) && (srcId[gi] != 3'd0);
      assign memHit[gi] = memValid_reg && memRegWrite_reg &&
                          (memRd_reg == srcId[gi]) && (srcId[gi] != 3'd0);
      // EX producer will sit in MEM when this instruction reaches EX, MEM producer in WB.
      assign fwd_next[gi] = exHit[gi]  ? FwdMem :
                            memHit[gi] ? FwdWb  : FwdBank;

      // Select travels with the instruction into EX; a bubble carries no forwarding.
      always_ff @(posedge clock) begin
        if (!reset) begin
          fwd_reg[gi] <= FwdBank;
        end else if (bubble) begin
          fwd_reg[gi] <= FwdBank;
        end else begin
          fwd_reg[gi] <= fwd_next[gi];
        end
      end
    end
  endgenerate

  assign saidaAfw = fwd_reg[0];
  assign saidaBfw = fwd_reg[1];

  // A load in EX cannot forward its data in time for a dependent ID instruction.
  assign stall  = exMemRead_reg && (exHit[0] || exHit[1]);
  assign taken  = exValid_reg && exBranch_reg && zeroEx;
  assign bubble = stall || taken;

  // A taken branch overrides the stall: the stalled instruction is squashed anyway,
  // and the front end must keep moving to fetch the branch target.
  assign pcWrite    = taken || !stall;
  assign ifidWrite  = taken || !stall;
  assign idexBubble = bubble;
  assign flushIfId  = taken;

  // Scoreboard advance: MEM takes EX, EX takes ID or a bubble.
  always_ff @(posedge clock) begin
    if (!reset) begin
      exValid_reg     <= 1'b0;
      exRd_reg        <= 3'd0;
      exRegWrite_reg  <= 1'b0;
      exMemRead_reg   <= 1'b0;
      exBranch_reg    <= 1'b0;
      memValid_reg    <= 1'b0;
      memRd_reg       <= 3'd0;
      memRegWrite_reg <= 1'b0;
    end else begin
      memValid_reg    <= exValid_reg;
      memRd_reg       <= exRd_reg;
      memRegWrite_reg <= exRegWrite_reg;
      if (bubble) begin
        exValid_reg    <= 1'b0;
        exRd_reg       <= 3'd0;
        exRegWrite_reg <= 1'b0;
        exMemRead_reg  <= 1'b0;
        exBranch_reg   <= 1'b0;
      end else begin
        exValid_reg    <= 1'b1;
        exRd_reg       <= rd_id;
        exRegWrite_reg <= regWrite_id;
        exMemRead_reg  <= memRead_id;
        exBranch_reg   <= branch_id;
      end
    end
  end

  // Counter step: hold at all-ones when saturating, otherwise roll over.
  function automatic logic [15:0] bump(input logic [15:0] cnt);
    if ((SAT_CNT != 0) && (cnt == 16'hFFFF)) begin
      return cnt;
    end
    return cnt + 16'd1;
  endfunction

  // Event counters; a flush cycle is never also counted as a stall.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stallCount_reg <= 16'd0;
      flushCount_reg <= 16'd0;
    end else if (taken) begin
      flushCount_reg <= bump(flushCount_reg);
    end else if (stall) begin
      stallCount_reg <= bump(stallCount_reg);
    end
  end

  assign stallCount = stallCount_reg;
  assign flushCount = flushCount_reg;

endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Pipeline hazard and forwarding controller for the 16-bit five-stage processor. It keeps a three-slot scoreboard (EX, MEM, WB) of in-flight destination registers fed from ID decode. From that scoreboard it produces registered forwarding selects for the EX-stage forward muxes, a one-cycle load-use stall, and a branch-taken flush of IF/ID and ID/EX. It sits beside the ID/EX pipeline register and drives PC/IF-ID write enables plus the `saidaAfw`/`saidaBfw` selects consumed by the EX stage.

## Interface
- `SAT_CNT`, default 1: 1 = event counters saturate at 0xFFFF, 0 = counters wrap.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low reset.
- `rs_id`  in  3  first source register of the instruction in ID.
- `rt_id`  in  3  second source register of the instruction in ID.
- `rd_id`  in  3  resolved destination register of the instruction in ID.
- `regWrite_id`  in  1  ID instruction writes the register bank.
- `memRead_id`  in  1  ID instruction is a load.
- `branch_id`  in  1  ID instruction is a conditional branch.
- `zeroEx`  in  1  ALU zero flag of the instruction in EX.
- `saidaAfw`  out  2  forward select, ALU operand A (EX instruction).
- `saidaBfw`  out  2  forward select, ALU operand B (EX instruction).
- `pcWrite`  out  1  PC update enable.
- `ifidWrite`  out  1  IF/ID register write enable.
- `idexBubble`  out  1  load zero control into ID/EX.
- `flushIfId`  out  1  clear IF/ID to NOP.
- `stallCount`  out  16  number of load-use stall cycles.
- `flushCount`  out  16  number of taken-branch flushes.

## Operation
- Scoreboard slot contents: {valid, rd, regWrite, memRead, branch}. Slots exist for EX, MEM and WB.
- Forward select encoding: 00 = register bank, 01 = `resultadoALU_MEM`, 10 = `resultadoMux_WB`. 11 is never driven.
- r0 is the zero register. A slot with rd = 0 never matches and never causes a forward or a stall.
- "Match(src, slot)" means: slot valid, slot regWrite, slot rd = src, and src != 0.
- Forward decision for operand A, made in ID and registered into EX:
  - Match(rs_id, EX slot) gives 01, because that instruction is in MEM next cycle.
  - Otherwise Match(rs_id, MEM slot) gives 10.
  - Otherwise 00.
  - The nearer stage wins.
- Operand B uses the same rule with `rt_id`.
- Load-use stall: `stall` = Match(rs_id or rt_id, EX slot) with EX slot memRead = 1. While `stall` is asserted:
  - `pcWrite` = 0, `ifidWrite` = 0, `idexBubble` = 1.
  - The ID instruction is held and re-evaluated next cycle.
- Branch taken: `taken` = EX slot valid, EX slot branch, and `zeroEx`. While `taken` is asserted:
  - `flushIfId` = 1, `idexBubble` = 1, `pcWrite` = 1.
  - `ifidWrite` = 1 so the branch target is fetched.
- `taken` has priority over `stall` in the same cycle. Only `flushCount` increments; `stallCount` does not.
- Slot advance every cycle: WB <= MEM, MEM <= EX.
  - EX <= bubble (all zero) if `stall` or `taken`.
  - Otherwise EX <= ID inputs, with valid = 1.
- Forward registers:
  - Load the newly computed codes when EX takes the ID instruction.
  - Load 00 when a bubble is inserted.
- Counters: `stallCount` increments on each `stall` cycle that is not also `taken`; `flushCount` increments on each `taken` cycle. Each counter saturates or wraps per `SAT_CNT`.

## Timing
- Reset (`reset` = 0 at a clock edge) takes effect at that edge and applies the following state:
  - All slots invalid.
  - `saidaAfw` = `saidaBfw` = 00.
  - Both counters 0.
- With all slots invalid the combinational outputs are `pcWrite` = 1, `ifidWrite` = 1, `idexBubble` = 0, `flushIfId` = 0.
- Asserting reset mid-stall or mid-flush drops the in-flight event; no counter increments on that edge.
- `stall`, `taken`, `pcWrite`, `ifidWrite`, `idexBubble` and `flushIfId` are combinational from the slots, the ID inputs and `zeroEx`. They are valid in the same cycle.
- `saidaAfw`/`saidaBfw` are registered. They are valid for the whole cycle the instruction occupies EX.
- A load-use stall lasts exactly 1 cycle. On the following cycle the load is in MEM and the dependent instruction gets forward code 10 one cycle later, i.e. from WB.
- A branch flush lasts exactly 1 cycle. The two younger instructions (in IF/ID and ID) are squashed.
- Counters update at the clock edge after the event cycle.

## Test plan
- Reset:
  - Hold `reset` = 0 for 2 cycles with arbitrary inputs.
  - Then all outputs read as follows: forwards 00, `pcWrite` = 1, `ifidWrite` = 1, `idexBubble` = 0, `flushIfId` = 0, counters 0.
- Back-to-back ALU forwarding:
  - Issue `add r3` (regWrite) followed by `sub` with rs = 3 and rt = 3.
  - Next cycle `saidaAfw` = `saidaBfw` = 01.
  - With one independent instruction between them, both read 10.
- Priority and r0:
  - r2 is written by both the EX slot and the MEM slot; ID rs = 2 gives `saidaAfw` = 01.
  - rd = 0 writers never produce a non-00 code or a stall.
- Load-use:
  - Issue `lw r4` then `add` with rt = 4.
  - Exactly one cycle of `pcWrite` = 0, `ifidWrite` = 0, `idexBubble` = 1.
  - Then `saidaBfw` = 10.
  - `stallCount` = 1.
- Branch:
  - `beq` in EX with `zeroEx` = 1 gives one cycle of `flushIfId` = 1 and `idexBubble` = 1; `flushCount` = 1.
  - With `zeroEx` = 0: no flush.
- Simultaneous events:
  - Taken branch in EX while ID has a load-use dependency on the EX slot.
  - Required: flush only, `pcWrite` = 1, `stallCount` unchanged.
  - Also, 65,540 stalls with `SAT_CNT` = 1 gives `stallCount` = 0xFFFF.
